// File: rtl/uart_pkg.sv
// Shared constants, CSR layout and TX sequencer states for the UART controller.
package uart_pkg;

    localparam logic [2:0] IO_OFFSET  = 3'h0;
    localparam logic [2:0] CSR_OFFSET = 3'h4;

    // CSR bit positions
    localparam int CSR_TX_EMPTY    = 0;
    localparam int CSR_TX_FULL     = 1;
    localparam int CSR_RX_NONEMPTY = 2;
    localparam int CSR_RX_FULL     = 3;
    localparam int CSR_RX_OVERRUN  = 4;
    localparam int CSR_TX_DROP     = 5;
    localparam int CSR_FSM_ACTIVE  = 6;
    localparam int CSR_RX_IRQ_EN   = 8;
    localparam int CSR_TX_IRQ_EN   = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

    // IO read word: flag bit 8 marks a real byte, an empty FIFO reads as zero.
    function automatic logic [31:0] io_read_word(input logic nonempty, input logic [7:0] head);
        logic [31:0] word;
        word = 32'd0;
        if (nonempty) begin
            word = {23'd0, 1'b1, head};
        end else begin
            word = 32'd0;
        end
        return word;
    endfunction

endpackage

// File: rtl/uart_ctrl_if.sv
// CPU load/store bus seen by the UART controller.
interface uart_ctrl_if;
    logic [2:0]  bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_addr, bus_we, bus_re, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_addr, bus_we, bus_re, bus_wdata,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop on empty is ignored and a
// push on full only lands when a pop frees a slot in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = mem_q[rptr_q[AW-1:0]];

    // Next pointers and storage contents.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (do_push_s) begin
            mem_d[wptr_q[AW-1:0]] = din;
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end
endmodule

// File: rtl/uart_ctrl.sv
// UART controller: bus-mapped IO/CSR registers, TX FIFO feeding a send
// sequencer for UartTx, RX FIFO capturing bytes from UartRx, level irq.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_ctrl_if.slave     bus,
    output logic           tx_send,
    output logic [7:0]     tx_data,
    input  logic           tx_busy,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           irq
);
    tx_state_t   state_q, state_d;
    logic        tx_send_q, tx_send_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        irq_q, irq_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        tx_drop_q, tx_drop_d;
    logic        rx_irq_en_q, rx_irq_en_d;
    logic        tx_irq_en_q, tx_irq_en_d;

    logic        io_wr_s, io_rd_s, csr_wr_s, csr_rd_s;
    logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic [7:0]  tx_head_s;
    logic        rx_pop_eff_s, rx_full_s, rx_empty_s;
    logic [7:0]  rx_head_s;
    logic [31:0] csr_word_s;
    logic        unused_wdata_bits;

    assign io_wr_s      = bus.bus_we & (bus.bus_addr == IO_OFFSET);
    assign io_rd_s      = bus.bus_re & (bus.bus_addr == IO_OFFSET);
    assign csr_wr_s     = bus.bus_we & (bus.bus_addr == CSR_OFFSET);
    assign csr_rd_s     = bus.bus_re & (bus.bus_addr == CSR_OFFSET);
    // A full TX FIFO drops the write even if the sequencer pops this cycle.
    assign tx_push_s    = io_wr_s & ~tx_full_s;
    assign rx_pop_eff_s = io_rd_s & ~rx_empty_s;
    assign unused_wdata_bits = ^bus.bus_wdata[31:10];

    uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .din   (bus.bus_wdata[7:0]),
        .dout  (tx_head_s),
        .full  (tx_full_s),
        .empty (tx_empty_s)
    );

    uart_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (io_rd_s),
        .din   (rx_data),
        .dout  (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s)
    );

    // TX sequencer: launch one byte, then wait for busy to rise and fall.
    always_comb begin
        state_d   = state_q;
        tx_pop_s  = 1'b0;
        tx_send_d = 1'b0;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: begin
                if (!tx_empty_s && !tx_busy) begin
                    tx_pop_s  = 1'b1;
                    tx_send_d = 1'b1;
                    tx_data_d = tx_head_s;
                    state_d   = WAIT_BUSY;
                end else begin
                    state_d   = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // CSR image assembled from live status and stored flags.
    always_comb begin
        csr_word_s                  = 32'd0;
        csr_word_s[CSR_TX_EMPTY]    = tx_empty_s;
        csr_word_s[CSR_TX_FULL]     = tx_full_s;
        csr_word_s[CSR_RX_NONEMPTY] = ~rx_empty_s;
        csr_word_s[CSR_RX_FULL]     = rx_full_s;
        csr_word_s[CSR_RX_OVERRUN]  = rx_overrun_q;
        csr_word_s[CSR_TX_DROP]     = tx_drop_q;
        csr_word_s[CSR_FSM_ACTIVE]  = (state_q != IDLE);
        csr_word_s[CSR_RX_IRQ_EN]   = rx_irq_en_q;
        csr_word_s[CSR_TX_IRQ_EN]   = tx_irq_en_q;
    end

    // Read data capture: sampled from pre-edge state, held until next read.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = bus.bus_re;
        if (io_rd_s) begin
            rdata_d = io_read_word(~rx_empty_s, rx_head_s);
        end else if (csr_rd_s) begin
            rdata_d = csr_word_s;
        end else if (bus.bus_re) begin
            rdata_d = 32'd0;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Sticky flags and enables; a new event wins over a same-cycle clear.
    always_comb begin
        rx_overrun_d = rx_overrun_q;
        tx_drop_d    = tx_drop_q;
        rx_irq_en_d  = rx_irq_en_q;
        tx_irq_en_d  = tx_irq_en_q;
        if (csr_wr_s) begin
            if (bus.bus_wdata[CSR_RX_OVERRUN]) begin
                rx_overrun_d = 1'b0;
            end else begin
                rx_overrun_d = rx_overrun_q;
            end
            if (bus.bus_wdata[CSR_TX_DROP]) begin
                tx_drop_d = 1'b0;
            end else begin
                tx_drop_d = tx_drop_q;
            end
            rx_irq_en_d = bus.bus_wdata[CSR_RX_IRQ_EN];
            tx_irq_en_d = bus.bus_wdata[CSR_TX_IRQ_EN];
        end else begin
            rx_irq_en_d = rx_irq_en_q;
            tx_irq_en_d = tx_irq_en_q;
        end
        if (rx_valid && rx_full_s && !rx_pop_eff_s) begin
            rx_overrun_d = 1'b1;
        end else begin
            rx_overrun_d = rx_overrun_d;
        end
        if (io_wr_s && tx_full_s) begin
            tx_drop_d = 1'b1;
        end else begin
            tx_drop_d = tx_drop_d;
        end
    end

    // Interrupt request from current status, registered.
    always_comb begin
        irq_d = (rx_irq_en_q & ~rx_empty_s) |
                (tx_irq_en_q & tx_empty_s & (state_q == IDLE));
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tx_send_q    <= 1'b0;
            tx_data_q    <= 8'd0;
            rdata_q      <= 32'd0;
            rvalid_q     <= 1'b0;
            irq_q        <= 1'b0;
            rx_overrun_q <= 1'b0;
            tx_drop_q    <= 1'b0;
            rx_irq_en_q  <= 1'b0;
            tx_irq_en_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_send_q    <= tx_send_d;
            tx_data_q    <= tx_data_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            irq_q        <= irq_d;
            rx_overrun_q <= rx_overrun_d;
            tx_drop_q    <= tx_drop_d;
            rx_irq_en_q  <= rx_irq_en_d;
            tx_irq_en_q  <= tx_irq_en_d;
        end
    end

    assign tx_send        = tx_send_q;
    assign tx_data        = tx_data_q;
    assign irq            = irq_q;
    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;
endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Memory-mapped controller that sequences the UART transmitter and buffers received bytes. Sits between the CPU load/store path and the UartTx/UartRx datapaths.
- Accepts CPU writes into a TX FIFO and issues one-cycle send pulses to UartTx, one byte at a time.
- Captures bytes from UartRx into an RX FIFO, drained by CPU reads.
- Exposes IO (offset 0x0) and CSR (offset 0x4) registers. Reading IO pops RX; writing IO pushes TX.

Parameters:
- TX_DEPTH, 4, TX FIFO entries (power of 2, ≥2)
- RX_DEPTH, 4, RX FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- bus_addr  in  3  byte offset; only 0x0 (IO) and 0x4 (CSR) decode, others ignored
- bus_we  in  1  write strobe, one cycle
- bus_re  in  1  read strobe, one cycle
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, registered
- bus_rvalid  out  1  read data valid
- tx_send  out  1  one-cycle pulse to UartTx
- tx_data  out  8  byte to UartTx, stable from the send pulse until UartTx deasserts busy
- tx_busy  in  1  UartTx shifting
- rx_valid  in  1  one-cycle pulse from UartRx, byte complete
- rx_data  in  8  received byte, valid with rx_valid
- irq  out  1  level interrupt request

Behaviour:
- Reset (rst=0, async):
  - FIFOs emptied, FSM to IDLE, all sticky flags and enables cleared.
  - bus_rdata=0, bus_rvalid=0, tx_send=0, tx_data=0, irq=0.
- IO write (we, addr 0x0):
  - Pushes wdata[7:0] to the TX FIFO.
  - If the FIFO is full, the byte is dropped and sticky tx_drop is set.
- IO read (re, addr 0x0):
  - bus_rdata={23'b0, rx_nonempty, head_byte}.
  - Pops the RX FIFO only if it is non-empty.
  - An empty read returns 0 and has no side effect.
- CSR read (re, addr 0x4):
  - bit0 tx_empty, bit1 tx_full, bit2 rx_nonempty, bit3 rx_full, bit4 rx_overrun, bit5 tx_drop, bit6 fsm_active (state≠IDLE), bit8 rx_irq_en, bit9 tx_irq_en.
  - All other bits read 0.
- CSR write (we, addr 0x4):
  - bit4=1 clears rx_overrun; bit5=1 clears tx_drop (write-1-to-clear).
  - bits 8 and 9 load the enables.
- Read latency: bus_rvalid pulses exactly one cycle after bus_re, and bus_rdata is held until the next read.
  - The read sample and the pop use the same edge as the strobe.
  - bus_we and bus_re together: the write is applied, the read returns pre-write state.
- TX FSM:
  - IDLE: leave when FIFO non-empty and tx_busy=0. On the transition, pop the head into tx_data and assert tx_send for one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when tx_busy=1.
  - WAIT_DONE: go to IDLE when tx_busy=0.
  - Minimum gap between two tx_send pulses is the busy duration plus 2 cycles. tx_send never fires while tx_busy=1.
  - An IO write into an empty FIFO while in IDLE gives tx_send two cycles after bus_we (push edge, then launch edge).
- RX:
  - rx_valid pushes rx_data.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and rx_overrun is set.
  - Push and pop in the same cycle on a full FIFO: both occur, no overrun.
  - Push and pop in the same cycle on an empty FIFO: the pop is ignored (returns empty) and the push lands.
- irq = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty & state==IDLE), registered.
- Pointers are log2(DEPTH)+1 bits, with the wrap bit distinguishing full from empty.
- Reset asserted mid-transmit drops tx_send and the FIFO contents immediately. UartTx is reset by the same rst.

Decomposition:
- Package uart_pkg holds:
  - IO_OFFSET=3'h0 and CSR_OFFSET=3'h4.
  - CSR bit-index localparams.
  - tx_state_t enum {IDLE, WAIT_BUSY, WAIT_DONE}.
- One sub-module uart_fifo (parameters DEPTH and WIDTH=8; ports push, pop, din, dout, full, empty), instantiated twice.

Test Plan:
1. Reset, then CSR read → rdata=0x00000001 (tx_empty only), rvalid one cycle after re; irq=0.
2. Write IO 0x41, 0x42, with tx_busy modelled as 10 cycles after each send → two tx_send pulses with tx_data 0x41 then 0x42, never while busy. After the last busy falls, CSR bit6=0.
3. Hold tx_busy=1 and write 5 bytes with TX_DEPTH=4 → the 5th is dropped and CSR bit5=1. Write CSR 0x20 → bit5 reads 0.
4. Inject rx bytes 0x10..0x14 with no reads → CSR shows rx_full and rx_overrun. IO reads return 0x110, 0x111, 0x112, 0x113, then 0x000.
5. With the RX FIFO full, rx_valid and IO read in the same cycle → returns the head byte, the new byte is queued, rx_overrun stays 0.
6. Set rx_irq_en (CSR write 0x100), inject 0x55 → irq=1; IO read returns 0x155 → irq=0. Reset asserted mid-WAIT_DONE → all outputs 0 asynchronously.
